// File: rtl/mil_manchester_tx_pkg.sv
// Shared MIL-STD-1553 word types, frame constants and parity helper for the
// Manchester-II transmitter and its half-bit timer.
package mil_manchester_tx_pkg;

  // Word types carried alongside each 16-bit payload.
  typedef enum logic [2:0] {
    WNULL    = 3'd0,
    WCOMMAND = 3'd1,
    WSTATUS  = 3'd2,
    WDATA    = 3'd3,
    WCONTROL = 3'd4,
    WERROR   = 3'd5
  } TDataType;

  // Frame layout in half-bits: 3+3 sync, then 17 Manchester cells.
  localparam int SYNC_HALFBITS = 6;
  localparam int DATA_HALFBITS = 34;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_GAP
  } tx_state_t;

  // Odd parity: returned bit makes the 17-bit total of ones odd.
  function automatic logic oddParity16(input logic [15:0] w);
    return ~(^w);
  endfunction

endpackage

// File: rtl/mil_manchester_tx_if.sv
// Push handshake between a word source and the Manchester transmitter.
interface mil_manchester_tx_if;
  import mil_manchester_tx_pkg::*;

  logic        in_request;
  TDataType    in_type;
  logic [15:0] in_word;
  logic        in_done;

  modport master (output in_request, output in_type, output in_word, input in_done);
  modport slave  (input in_request, input in_type, input in_word, output in_done);

endinterface

// File: rtl/mil_manchester_tx_halfbit_timer.sv
// Free-running half-bit tick generator with synchronous clear; tick is high
// on the last clock of each half-bit period.
module mil_halfbit_timer #(
  parameter int CLK_PER_HALFBIT = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_PER_HALFBIT > 1) ? $clog2(CLK_PER_HALFBIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_HALFBIT - 1);

  logic [CW-1:0] cnt;

  // Count clocks within a half-bit, wrapping at the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/mil_manchester_tx.sv
// MIL-STD-1553 Manchester-II word transmitter: one-word holding register,
// sync + 16 data bits + odd parity onto a differential line pair.
module mil_manchester_tx
  import mil_manchester_tx_pkg::*;
#(
  parameter int CLK_PER_HALFBIT = 25,
  parameter int GAP_HALFBITS    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  mil_manchester_tx_if.slave  bus,
  output logic                tx_out,
  output logic                ntx_out,
  output logic                busy,
  output logic                type_error
);

  tx_state_t   state, state_nxt;
  logic [15:0] hb, hb_nxt;
  logic        load;
  logic        tick;

  logic        hold_full;
  TDataType    hold_type;
  logic [15:0] hold_word;

  logic [16:0] frame;
  logic        sync_cs;

  logic        accept, accept_ok, start_ok;
  logic        done_r;
  logic        lvl;

  assign accept    = bus.in_request && !hold_full;
  assign accept_ok = accept && (bus.in_type inside {WCOMMAND, WSTATUS, WDATA});
  assign start_ok  = hold_full && enable;

  mil_halfbit_timer #(.CLK_PER_HALFBIT(CLK_PER_HALFBIT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state == ST_IDLE),
    .tick  (tick)
  );

  // State register and half-bit index within the current phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      hb    <= '0;
    end else begin
      state <= state_nxt;
      hb    <= hb_nxt;
    end
  end

  // Next-state: phase sequencing on half-bit ticks, back-to-back chaining.
  always_comb begin
    state_nxt = state;
    hb_nxt    = hb;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nxt = ST_SYNC;
          hb_nxt    = '0;
          load      = 1'b1;
        end
      end
      ST_SYNC: begin
        if (tick) begin
          if (hb == 16'(SYNC_HALFBITS - 1)) begin
            state_nxt = ST_DATA;
            hb_nxt    = '0;
          end else begin
            hb_nxt = hb + 16'd1;
          end
        end
      end
      ST_DATA, ST_GAP: begin
        if (tick) begin
          hb_nxt = hb + 16'd1;
          if (state == ST_DATA && hb == 16'(DATA_HALFBITS - 1) && GAP_HALFBITS > 0) begin
            state_nxt = ST_GAP;
            hb_nxt    = '0;
          end else if ((state == ST_DATA && hb == 16'(DATA_HALFBITS - 1)) ||
                       (state == ST_GAP  && hb == 16'(GAP_HALFBITS - 1))) begin
            hb_nxt = '0;
            if (start_ok) begin
              state_nxt = ST_SYNC;
              load      = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        hb_nxt    = '0;
      end
    endcase
  end

  // Line levels from phase, half-bit index and the current frame bit.
  always_comb begin
    lvl     = 1'b0;
    tx_out  = 1'b0;
    ntx_out = 1'b0;
    case (state)
      ST_SYNC: begin
        lvl     = sync_cs ? (hb < 16'd3) : (hb >= 16'd3);
        tx_out  = lvl;
        ntx_out = !lvl;
      end
      ST_DATA: begin
        lvl     = hb[0] ? !frame[16] : frame[16];
        tx_out  = lvl;
        ntx_out = !lvl;
      end
      default: begin
        lvl     = 1'b0;
        tx_out  = 1'b0;
        ntx_out = 1'b0;
      end
    endcase
  end

  // Handshake control: holding-register flag, done and type-error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full  <= 1'b0;
      done_r     <= 1'b0;
      type_error <= 1'b0;
    end else begin
      hold_full  <= (hold_full && !load) || accept_ok;
      done_r     <= accept;
      type_error <= accept && !accept_ok;
    end
  end

  // Holding register contents, latched on a valid accept.
  always_ff @(posedge clk) begin
    if (accept_ok) begin
      hold_type <= bus.in_type;
      hold_word <= bus.in_word;
    end
  end

  // Shift register: load word plus parity, shift after each full cell.
  always_ff @(posedge clk) begin
    if (load) begin
      frame   <= {hold_word, oddParity16(hold_word)};
      sync_cs <= (hold_type != WDATA);
    end else if (state == ST_DATA && tick && hb[0]) begin
      frame <= {frame[15:0], 1'b0};
    end
  end

  assign bus.in_done = done_r;
  assign busy        = (state != ST_IDLE) || hold_full;

endmodule

// File: tb/tb_mil_manchester_tx.sv
// Directed bench for mil_manchester_tx: frame waveforms, handshake, type
// rejection, enable gating and asynchronous reset mid-word.
module tb_mil_manchester_tx;
  import mil_manchester_tx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic tx_out, ntx_out, busy, type_error;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int pair_cnt = 0;

  typedef struct {
    TDataType    t;
    logic [15:0] w;
  } item_t;
  item_t q[$];

  mil_manchester_tx_if bus ();

  mil_manchester_tx #(.CLK_PER_HALFBIT(25), .GAP_HALFBITS(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .bus        (bus),
    .tx_out     (tx_out),
    .ntx_out    (ntx_out),
    .busy       (busy),
    .type_error (type_error)
  );

  always #10 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!(tx_out || ntx_out) && n < 3000) begin
      step(1);
      n++;
    end
    chk(tag, 32'(tx_out | ntx_out), 1);
  endtask

  // Checks 1000 clocks of one frame starting at the current sample point,
  // ending on the sample point 1000 clocks later.
  task automatic check_frame(input logic cs, input logic [15:0] w, input logic par,
                             input string tag);
    logic lv [40];
    for (int h = 0; h < 6; h++) lv[h] = cs ? (h < 3) : (h >= 3);
    for (int i = 0; i < 16; i++) begin
      lv[6 + 2*i] = w[15 - i];
      lv[7 + 2*i] = !w[15 - i];
    end
    lv[38] = par;
    lv[39] = !par;
    for (int k = 0; k < 1000; k++) begin
      chk({tag, "_tx"}, 32'(tx_out), 32'(lv[k / 25]));
      chk({tag, "_ntx"}, 32'(ntx_out), 32'(!lv[k / 25]));
      chk({tag, "_busy"}, 32'(busy), 1);
      step(1);
    end
  endtask

  // Word source: presents the queue head, retires it on each done.
  initial begin
    bus.in_request = 1'b0;
    bus.in_type    = WNULL;
    bus.in_word    = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.in_done) begin
        done_cnt++;
        if (type_error) pair_cnt++;
        if (q.size() > 0) q.delete(0);
      end
      if (q.size() > 0) begin
        bus.in_request = 1'b1;
        bus.in_type    = q[0].t;
        bus.in_word    = q[0].w;
      end else begin
        bus.in_request = 1'b0;
      end
    end
  end

  initial begin
    int d0, p0;

    // Reset state
    step(3);
    chk("rst_tx", 32'(tx_out), 0);
    chk("rst_ntx", 32'(ntx_out), 0);
    chk("rst_done", 32'(bus.in_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_terr", 32'(type_error), 0);
    rst = 1'b0;
    step(2);

    // Command EFAB then data 02A1, contiguous, both parity 1
    q.push_back('{WCOMMAND, 16'hEFAB});
    q.push_back('{WDATA, 16'h02A1});
    wait_start("start_efab");
    check_frame(1'b1, 16'hEFAB, 1'b1, "efab");
    check_frame(1'b0, 16'h02A1, 1'b1, "w02a1");
    chk("idle1_tx", 32'(tx_out), 0);
    chk("idle1_ntx", 32'(ntx_out), 0);
    chk("idle1_busy", 32'(busy), 0);
    chk("done_cnt2", 32'(done_cnt), 2);

    // Data 0001: exact done timing and waveform, parity 0
    step(3);
    q.push_back('{WDATA, 16'h0001});
    step(1);
    chk("d0001_done", 32'(bus.in_done), 1);
    chk("d0001_terr", 32'(type_error), 0);
    step(1);
    chk("d0001_done_low", 32'(bus.in_done), 0);
    chk("d0001_start", 32'(ntx_out), 1);
    check_frame(1'b0, 16'h0001, 1'b0, "d0001");
    chk("idle2_tx", 32'(tx_out | ntx_out), 0);
    chk("idle2_busy", 32'(busy), 0);

    // Four words with request held throughout
    step(3);
    d0 = done_cnt;
    q.push_back('{WSTATUS, 16'h1234});
    q.push_back('{WDATA, 16'h8000});
    q.push_back('{WDATA, 16'hFFFF});
    q.push_back('{WCOMMAND, 16'h0000});
    wait_start("start_four");
    check_frame(1'b1, 16'h1234, 1'b0, "f1234");
    check_frame(1'b0, 16'h8000, 1'b0, "f8000");
    check_frame(1'b0, 16'hFFFF, 1'b1, "fffff");
    check_frame(1'b1, 16'h0000, 1'b1, "f0000");
    chk("idle3_tx", 32'(tx_out | ntx_out), 0);
    chk("idle3_busy", 32'(busy), 0);
    step(2);
    chk("four_dones", 32'(done_cnt - d0), 4);

    // Unsupported type: done with type_error, nothing sent
    d0 = done_cnt;
    p0 = pair_cnt;
    q.push_back('{WCONTROL, 16'h5A5A});
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("bad_lines", 32'(tx_out | ntx_out), 0);
      chk("bad_busy", 32'(busy), 0);
    end
    chk("bad_done", 32'(done_cnt - d0), 1);
    chk("bad_pair", 32'(pair_cnt - p0), 1);

    // enable low: accepted and held, sent once enable rises
    enable = 1'b0;
    d0 = done_cnt;
    q.push_back('{WDATA, 16'h5555});
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold_lines", 32'(tx_out | ntx_out), 0);
    end
    chk("hold_busy", 32'(busy), 1);
    chk("hold_done", 32'(done_cnt - d0), 1);
    enable = 1'b1;
    step(1);
    chk("en_start", 32'(ntx_out), 1);
    check_frame(1'b0, 16'h5555, 1'b1, "d5555");
    chk("idle4_busy", 32'(busy), 0);

    // Asynchronous reset 500 clocks into a word
    step(3);
    q.push_back('{WCOMMAND, 16'hABCD});
    wait_start("start_abcd");
    step(500);
    chk("mid_active", 32'(tx_out ^ ntx_out), 1);
    rst = 1'b1;
    #2;
    chk("arst_tx", 32'(tx_out), 0);
    chk("arst_ntx", 32'(ntx_out), 0);
    chk("arst_busy", 32'(busy), 0);
    step(2);
    rst = 1'b0;
    step(3);
    chk("post_rst_lines", 32'(tx_out | ntx_out), 0);
    q.push_back('{WDATA, 16'hFFFF});
    step(1);
    chk("ffff_done", 32'(bus.in_done), 1);
    step(1);
    chk("ffff_start", 32'(ntx_out), 1);
    check_frame(1'b0, 16'hFFFF, 1'b1, "rffff");
    chk("idle5_lines", 32'(tx_out | ntx_out), 0);
    chk("idle5_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
